// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave = cache, master = fetch stage plus memory controller.
interface icache_if #(
  parameter int ADDR_LEN   = 20,
  parameter int LINE_WIDTH = 128,
  parameter int WORD_WIDTH = 32
);
  logic                  fetch_valid;
  logic [ADDR_LEN-1:0]   fetch_addr;
  logic [WORD_WIDTH-1:0] instr;
  logic                  hit;
  logic                  stall;
  logic                  from_icache;
  logic [ADDR_LEN-1:0]   addr_icache;
  logic [LINE_WIDTH-1:0] data_to_cache;
  logic                  read_ready_for_icache;

  modport slave (
    input  fetch_valid,
    input  fetch_addr,
    output instr,
    output hit,
    output stall,
    output from_icache,
    output addr_icache,
    input  data_to_cache,
    input  read_ready_for_icache
  );

  modport master (
    output fetch_valid,
    output fetch_addr,
    input  instr,
    input  hit,
    input  stall,
    input  from_icache,
    input  addr_icache,
    output data_to_cache,
    output read_ready_for_icache
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with 0-cycle hits
// and a rising-edge-qualified line fill from the memory controller.
module icache_ctrl #(
  parameter int ADDR_LEN   = 20,
  parameter int LINE_WIDTH = 128,
  parameter int WORD_WIDTH = 32,
  parameter int NUM_LINES  = 4
) (
  input  logic     clk,
  input  logic     reset,
  icache_if.slave  bus
);

  localparam int OFF_W   = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_LEN - OFF_W - IDX_W;
  localparam int LINE_AW = ADDR_LEN - OFF_W;
  localparam int WPL     = LINE_WIDTH / WORD_WIDTH;
  localparam int WSEL_W  = $clog2(WPL);

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINE_WIDTH-1:0] r_data [NUM_LINES];
  logic [TAG_W-1:0]      r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0]  r_valid;
  logic [LINE_AW-1:0]    r_miss_line;
  logic                  r_ready_q;

  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_idx;
  logic [WSEL_W-1:0]     w_wsel;
  logic [TAG_W-1:0]      w_miss_tag;
  logic [IDX_W-1:0]      w_miss_idx;
  logic [LINE_WIDTH-1:0] w_line;
  logic [WORD_WIDTH-1:0] w_word;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_fill;
  logic                  w_stall;
  logic                  w_req;
  logic                  w_unused;

  assign w_tag      = bus.fetch_addr[ADDR_LEN-1 -: TAG_W];
  assign w_idx      = bus.fetch_addr[OFF_W +: IDX_W];
  assign w_wsel     = bus.fetch_addr[2 +: WSEL_W];
  assign w_unused   = ^bus.fetch_addr[1:0];
  assign w_miss_tag = r_miss_line[LINE_AW-1 -: TAG_W];
  assign w_miss_idx = r_miss_line[IDX_W-1:0];

  assign w_hit = bus.fetch_valid && r_valid[w_idx] &&
                 (r_tag[w_idx] == w_tag) && (r_state == IDLE);
  assign w_miss = bus.fetch_valid && !w_hit && (r_state == IDLE);
  // A ready level left high by an earlier fill must not refill
  assign w_fill = (r_state == MISS_WAIT) &&
                  bus.read_ready_for_icache && !r_ready_q;

  always_comb begin
    w_line = r_data[w_idx];
    w_word = '0;
    for (int i = 0; i < WPL; i++) begin
      if (w_wsel == WSEL_W'(i)) begin
        w_word = w_line[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_req   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_miss) w_next = MISS_REQ;
      end
      MISS_REQ: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        w_next  = MISS_WAIT;
      end
      MISS_WAIT: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        if (w_fill) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ready_q   <= 1'b0;
      r_valid     <= '0;
      r_miss_line <= '0;
    end else begin
      r_state   <= w_next;
      r_ready_q <= bus.read_ready_for_icache;
      if (w_miss) r_miss_line <= bus.fetch_addr[ADDR_LEN-1:OFF_W];
      if (w_fill) r_valid[w_miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_miss_idx] <= bus.data_to_cache;
      r_tag[w_miss_idx]  <= w_miss_tag;
    end
  end

  assign bus.hit         = w_hit;
  assign bus.instr       = w_hit ? w_word : '0;
  assign bus.stall       = w_stall;
  assign bus.from_icache = w_req;
  assign bus.addr_icache = w_req ? {r_miss_line, {OFF_W{1'b0}}} : '0;

endmodule
